pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 31 +++
 rtl/pc_btb.sv | 78 +++++++
 rtl/pc_unit.sv | 81 ++++++++
 tb/tb_pc_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared constants and types for the fetch PC unit and its branch target buffer.
// BTB entry fields are sized for the widest supported PC (32 bits); narrower builds zero-extend.
package pc_pkg;

  localparam int unsigned PC_OFFSET   = 4;
  localparam int unsigned BTB_FIELD_W = 32;

  typedef enum logic [1:0] {
    CNT_STRONG_NT = 2'b00,
    CNT_WEAK_NT   = 2'b01,
    CNT_WEAK_T    = 2'b10,
    CNT_STRONG_T  = 2'b11
  } btb_cnt_e;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    btb_cnt_e               counter;
    logic [BTB_FIELD_W-1:0] target;
  } btb_entry_t;

  function automatic int unsigned btb_idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned btb_tag_width(input int unsigned data_width,
                                                input int unsigned depth);
    return data_width - $clog2(depth) - 2;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational on the current PC; updates land on the next rising edge.
module pc_btb
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BTB_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lookup_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  update_valid,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  update_taken
);

  localparam int unsigned IDX_W = btb_idx_width(BTB_DEPTH);

  btb_entry_t             entries_q [BTB_DEPTH];
  btb_entry_t             entries_d [BTB_DEPTH];
  btb_entry_t             up_entry;
  logic [IDX_W-1:0]       lk_idx;
  logic [IDX_W-1:0]       up_idx;
  logic [BTB_FIELD_W-1:0] lk_tag;
  logic [BTB_FIELD_W-1:0] up_tag;
  logic                   up_hit;
  logic                   unused_low_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign lk_tag = BTB_FIELD_W'(lookup_pc[DATA_WIDTH-1:IDX_W+2]);
  assign up_tag = BTB_FIELD_W'(update_pc[DATA_WIDTH-1:IDX_W+2]);
  assign unused_low_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  // Lookup reads registered contents, so a same-index update is only seen next cycle.
  assign pred_taken  = entries_q[lk_idx].valid && (entries_q[lk_idx].tag == lk_tag)
                       && entries_q[lk_idx].counter[1];
  assign pred_target = entries_q[lk_idx].target[DATA_WIDTH-1:0];

  always_comb begin
    entries_d = entries_q;
    up_entry  = entries_q[up_idx];
    up_hit    = up_entry.valid && (up_entry.tag == up_tag);
    if (update_valid) begin
      if (up_hit) begin
        if (update_taken) begin
          if (up_entry.counter != CNT_STRONG_T) begin
            up_entry.counter = btb_cnt_e'(up_entry.counter + 2'd1);
          end
          up_entry.target = BTB_FIELD_W'(update_target);
        end else if (up_entry.counter != CNT_STRONG_NT) begin
          up_entry.counter = btb_cnt_e'(up_entry.counter - 2'd1);
        end
        entries_d[up_idx] = up_entry;
      end else if (update_taken) begin
        entries_d[up_idx] = '{valid:   1'b1,
                              tag:     up_tag,
                              counter: CNT_WEAK_T,
                              target:  BTB_FIELD_W'(update_target)};
      end
    end
  end

  // Only valid bits are reset; stale tags/targets are harmless once invalidated.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch PC register and next-PC selection: reset > redirect > stall > BTB prediction > PC+4.
// Define PC_UNIT_BTB_EN to build the branch target buffer; without it prediction is disabled.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                    BTB_DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  update_valid,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  update_taken,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] inc_PC,
  output logic                  pred_taken,
  output logic                  misaligned
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;
  logic [DATA_WIDTH-1:0] pred_target;
  logic                  misaligned_q;
  logic                  misaligned_d;

  assign PC         = pc_q;
  assign inc_PC     = pc_q + DATA_WIDTH'(PC_OFFSET);
  assign misaligned = misaligned_q;

`ifdef PC_UNIT_BTB_EN
  pc_btb #(
    .DATA_WIDTH (DATA_WIDTH),
    .BTB_DEPTH  (BTB_DEPTH)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_q),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .update_valid  (update_valid),
    .update_pc     (update_pc),
    .update_target (update_target),
    .update_taken  (update_taken)
  );
`else
  logic unused_update;
  assign pred_taken    = 1'b0;
  assign pred_target   = '0;
  assign unused_update = ^{update_valid, update_pc, update_target, update_taken};
`endif

  // Redirect targets follow the JALR rule (bit 0 cleared); bit 1 set is flagged, not fixed.
  always_comb begin
    misaligned_d = redirect_valid && redirect_target[1];
    if (redirect_valid) begin
      pc_d = {redirect_target[DATA_WIDTH-1:1], 1'b0};
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end else begin
      pc_d = inc_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic against a reference model.
// Expectations adapt to whether PC_UNIT_BTB_EN is defined for the build.
module tb_pc_unit;

`ifdef PC_UNIT_BTB_EN
   localparam bit BTB_EN = 1'b1;
`else
   localparam bit BTB_EN = 1'b0;
`endif

   localparam logic [31:0] RV = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirectValid;
   logic [31:0] redirectTarget;
   logic        updateValid;
   logic [31:0] updatePc;
   logic [31:0] updateTarget;
   logic        updateTaken;
   logic [31:0] pcOut;
   logic [31:0] incPcOut;
   logic        predTakenOut;
   logic        misalignedOut;

   int checkCount = 0;
   int failCount  = 0;

   // Reference model: fetch address plus a table of 16 entries keyed by word address.
   bit          modelInit = 1'b0;
   logic [31:0] modelPc;
   bit          modelMis;
   bit          btbValid [16];
   logic [31:0] btbTag [16];
   logic [31:0] btbTarget [16];
   int          btbCount [16];

   pc_unit #(
      .DATA_WIDTH   (32),
      .RESET_VECTOR (RV),
      .BTB_DEPTH    (16)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirectValid),
      .redirect_target (redirectTarget),
      .update_valid    (updateValid),
      .update_pc       (updatePc),
      .update_target   (updateTarget),
      .update_taken    (updateTaken),
      .PC              (pcOut),
      .inc_PC          (incPcOut),
      .pred_taken      (predTakenOut),
      .misaligned      (misalignedOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic int slotOf(input logic [31:0] addr);
      return int'((addr / 4) % 16);
   endfunction

   function automatic bit modelPredicts(input logic [31:0] addr);
      int s;
      s = slotOf(addr);
      return BTB_EN && btbValid[s] && (btbTag[s] == addr / 64) && (btbCount[s] >= 2);
   endfunction

   // One clock: check current outputs at the falling edge, drive inputs, advance the model.
   task automatic applyStimulus(input bit r, input bit st, input bit rv, input logic [31:0] rt,
                                input bit uv, input logic [31:0] upc, input logic [31:0] ut,
                                input bit utk);
      bit pred;
      int s;
      @(negedge clk);
      if (modelInit) begin
         checkOutput("pc", pcOut, modelPc);
         checkOutput("inc_pc", incPcOut, modelPc + 32'd4);
         checkOutput("pred_taken", {31'd0, predTakenOut}, {31'd0, modelPredicts(modelPc)});
         checkOutput("misaligned", {31'd0, misalignedOut}, {31'd0, modelMis});
      end
      rst            = r;
      stall          = st;
      redirectValid  = rv;
      redirectTarget = rt;
      updateValid    = uv;
      updatePc       = upc;
      updateTarget   = ut;
      updateTaken    = utk;
      if (r) begin
         modelPc   = RV;
         modelMis  = 1'b0;
         modelInit = 1'b1;
         for (int i = 0; i < 16; i++) btbValid[i] = 1'b0;
      end else begin
         pred     = modelPredicts(modelPc);
         modelMis = rv && rt[1];
         if (rv) modelPc = rt & ~32'd1;
         else if (!st) modelPc = pred ? btbTarget[slotOf(modelPc)] : modelPc + 32'd4;
         if (uv && BTB_EN) begin
            s = slotOf(upc);
            if (btbValid[s] && btbTag[s] == upc / 64) begin
               if (utk) begin
                  btbCount[s]  = (btbCount[s] < 3) ? btbCount[s] + 1 : 3;
                  btbTarget[s] = ut;
               end else begin
                  btbCount[s] = (btbCount[s] > 0) ? btbCount[s] - 1 : 0;
               end
            end else if (utk) begin
               btbValid[s]  = 1'b1;
               btbTag[s]    = upc / 64;
               btbCount[s]  = 2;
               btbTarget[s] = ut;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic redirectTo(input logic [31:0] t);
      applyStimulus(1'b0, 1'b0, 1'b1, t, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit          r, st, rv, uv, utk;
      logic [31:0] rt, upc, ut;

      rst = 1'b1; stall = 1'b0; redirectValid = 1'b0; redirectTarget = '0;
      updateValid = 1'b0; updatePc = '0; updateTarget = '0; updateTaken = 1'b0;

      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      rst = 1'b0;

      // Free run out of reset.
      checkOutput("reset_pc", pcOut, 32'h100);
      checkOutput("reset_pred", {31'd0, predTakenOut}, 32'd0);
      checkOutput("reset_mis", {31'd0, misalignedOut}, 32'd0);
      idleCycle();
      checkOutput("run_pc1", pcOut, 32'h104);
      idleCycle();
      checkOutput("run_pc2", pcOut, 32'h108);
      idleCycle();
      checkOutput("run_pc3", pcOut, 32'h10C);

      // Redirect beats stall; bit 0 cleared, bit 1 flagged for one cycle.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0, 32'h0, 1'b0);
      checkOutput("redir_pc", pcOut, 32'h202);
      checkOutput("redir_mis", {31'd0, misalignedOut}, 32'd1);
      idleCycle();
      checkOutput("mis_pulse_end", {31'd0, misalignedOut}, 32'd0);
      checkOutput("after_redir_pc", pcOut, 32'h206);

      // Allocate 0x40 -> 0x80, then fetch 0x40.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 32'h80, 1'b1);
      redirectTo(32'h40);
      checkOutput("alloc_pred", {31'd0, predTakenOut}, {31'd0, BTB_EN});
      idleCycle();
      checkOutput("alloc_next", pcOut, BTB_EN ? 32'h80 : 32'h44);

      // Two not-taken updates drop the counter to strong not-taken.
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 1'b0);
      redirectTo(32'h40);
      checkOutput("nt_pred", {31'd0, predTakenOut}, 32'd0);
      idleCycle();
      checkOutput("nt_next", pcOut, 32'h44);

      // Wrap of PC+4 at the top of the address space.
      redirectTo(32'hFFFF_FFFC);
      checkOutput("wrap_inc", incPcOut, 32'h0);
      idleCycle();
      checkOutput("wrap_pc", pcOut, 32'h0);

      // Reset during stall, misaligned redirect and a taken update discards all three.
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h502, 1'b1, 32'h40, 32'h80, 1'b1);
      rst = 1'b0;
      checkOutput("rst_drop_pc", pcOut, RV);
      checkOutput("rst_drop_mis", {31'd0, misalignedOut}, 32'd0);
      redirectTo(32'h40);
      checkOutput("rst_drop_upd", {31'd0, predTakenOut}, 32'd0);

      // Random traffic over a small address pool so lookups, aliases and updates collide.
      for (int n = 0; n < 400; n++) begin
         r   = ($urandom_range(0, 99) < 2);
         st  = ($urandom_range(0, 99) < 25);
         rv  = ($urandom_range(0, 99) < 12);
         rt  = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
         uv  = ($urandom_range(0, 99) < 40);
         upc = 32'($urandom_range(0, 63)) << 2;
         ut  = 32'($urandom_range(0, 63)) << 2;
         utk = ($urandom_range(0, 99) < 60);
         applyStimulus(r, st, rv, rt, uv, upc, ut, utk);
      end
      idleCycle();

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
